// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared note frequencies, note indices and FSM encoding for tone_player
package tone_pkg;

    // Note frequencies in Hz, rounded to the nearest integer
    localparam int F_C4 = 262;
    localparam int F_D4 = 294;
    localparam int F_E4 = 330;
    localparam int F_F4 = 349;
    localparam int F_G4 = 392;
    localparam int F_A4 = 440;
    localparam int F_B4 = 494;
    localparam int F_C5 = 523;
    localparam int F_D5 = 587;
    localparam int F_E5 = 659;
    localparam int F_F5 = 698;
    localparam int F_G5 = 784;
    localparam int F_A5 = 880;
    localparam int F_B5 = 988;
    localparam int F_C6 = 1047;
    localparam int F_D6 = 1175;

    typedef enum logic [3:0] {
        NOTE_C4 = 4'd0,
        NOTE_D4 = 4'd1,
        NOTE_E4 = 4'd2,
        NOTE_F4 = 4'd3,
        NOTE_G4 = 4'd4,
        NOTE_A4 = 4'd5,
        NOTE_B4 = 4'd6,
        NOTE_C5 = 4'd7,
        NOTE_D5 = 4'd8,
        NOTE_E5 = 4'd9,
        NOTE_F5 = 4'd10,
        NOTE_G5 = 4'd11,
        NOTE_A5 = 4'd12,
        NOTE_B5 = 4'd13,
        NOTE_C6 = 4'd14,
        NOTE_D6 = 4'd15
    } note_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

endpackage

// File: rtl/tone_period_rom.sv
// rtl/tone_period_rom.sv - combinational note index to full-period (clock cycles) lookup
module tone_period_rom
    import tone_pkg::*;
#(
    parameter int CLOCK_FREQ = 12000000
) (
    input  logic [3:0]  note_sel,
    output logic [31:0] period
);

    // Full period of each note, evaluated at elaboration time
    always_comb begin
        period = 32'(CLOCK_FREQ / F_A4);
        case (note_t'(note_sel))
            NOTE_C4: period = 32'(CLOCK_FREQ / F_C4);
            NOTE_D4: period = 32'(CLOCK_FREQ / F_D4);
            NOTE_E4: period = 32'(CLOCK_FREQ / F_E4);
            NOTE_F4: period = 32'(CLOCK_FREQ / F_F4);
            NOTE_G4: period = 32'(CLOCK_FREQ / F_G4);
            NOTE_A4: period = 32'(CLOCK_FREQ / F_A4);
            NOTE_B4: period = 32'(CLOCK_FREQ / F_B4);
            NOTE_C5: period = 32'(CLOCK_FREQ / F_C5);
            NOTE_D5: period = 32'(CLOCK_FREQ / F_D5);
            NOTE_E5: period = 32'(CLOCK_FREQ / F_E5);
            NOTE_F5: period = 32'(CLOCK_FREQ / F_F5);
            NOTE_G5: period = 32'(CLOCK_FREQ / F_G5);
            NOTE_A5: period = 32'(CLOCK_FREQ / F_A5);
            NOTE_B5: period = 32'(CLOCK_FREQ / F_B5);
            NOTE_C6: period = 32'(CLOCK_FREQ / F_C6);
            NOTE_D6: period = 32'(CLOCK_FREQ / F_D6);
            default: period = 32'(CLOCK_FREQ / F_A4);
        endcase
    end

endmodule

// File: rtl/tone_player.sv
// rtl/tone_player.sv - plays one square-wave note per command for a tick-counted duration
module tone_player
    import tone_pkg::*;
#(
    parameter int CLOCK_FREQ = 12000000,
    parameter int TICK_HZ    = 1000,
    parameter int DUR_W      = 16,
    parameter int OCT_W      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       note_sel,
    input  logic [OCT_W-1:0] octave,
    input  logic [DUR_W-1:0] duration,
    output logic             ready,
    output logic             busy,
    output logic             tone_out,
    output logic             done
);

    localparam int TICK_DIV = CLOCK_FREQ / TICK_HZ;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [0:0]       state;
    logic [31:0]      period;
    logic [31:0]      half_next;
    logic [31:0]      half_r;
    logic [31:0]      hcnt;
    logic [PRE_W-1:0] pre;
    logic [DUR_W-1:0] dur_r;
    logic [DUR_W-1:0] tcnt;

    tone_period_rom #(
        .CLOCK_FREQ (CLOCK_FREQ)
    ) u_rom (
        .note_sel (note_sel),
        .period   (period)
    );

    // Half period for the requested octave; never zero so the toggle compare stays valid
    always_comb begin
        half_next = (period >> 1) >> octave;
        if (half_next == 32'd0) begin
            half_next = 32'd1;
        end
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_PLAY);

    // Command accept, tone toggling and tick-based duration countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            half_r   <= '0;
            hcnt     <= '0;
            pre      <= '0;
            dur_r    <= '0;
            tcnt     <= '0;
            tone_out <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        half_r <= half_next;
                        dur_r  <= duration;
                        hcnt   <= '0;
                        pre    <= '0;
                        tcnt   <= '0;
                        if (duration == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= ST_PLAY;
                            tone_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (hcnt == half_r - 32'd1) begin
                        hcnt     <= '0;
                        tone_out <= ~tone_out;
                    end else begin
                        hcnt <= hcnt + 32'd1;
                    end
                    if (pre == PRE_W'(TICK_DIV - 1)) begin
                        pre  <= '0;
                        tcnt <= tcnt + DUR_W'(1);
                        if (tcnt == dur_r - DUR_W'(1)) begin
                            state    <= ST_IDLE;
                            tone_out <= 1'b0;
                            done     <= 1'b1;
                        end
                    end else begin
                        pre <= pre + PRE_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_player.sv
// tb/tb_tone_player.sv - directed self-checking bench for tone_player
module tb_tone_player;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  note_sel;
    logic [1:0]  octave;
    logic [15:0] duration;
    logic        ready, busy, tone_out, done;

    logic        start2;
    logic [3:0]  note_sel2;
    logic [1:0]  octave2;
    logic [15:0] duration2;
    logic        ready2, busy2, tone2, done2;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_n;
    int done_seen;
    int nruns;
    int runs [0:7];

    always #5 clk = ~clk;

    tone_player dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .note_sel (note_sel),
        .octave   (octave),
        .duration (duration),
        .ready    (ready),
        .busy     (busy),
        .tone_out (tone_out),
        .done     (done)
    );

    tone_player #(
        .CLOCK_FREQ (8),
        .TICK_HZ    (1)
    ) dut_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .note_sel (note_sel2),
        .octave   (octave2),
        .duration (duration2),
        .ready    (ready2),
        .busy     (busy2),
        .tone_out (tone2),
        .done     (done2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Follow one note until busy drops, recording tone run lengths; optionally poke start mid-note
    task automatic measure(input int limit, input int poke_at);
        int   run;
        logic lvl;
        busy_n    = 0;
        done_seen = 0;
        nruns     = 0;
        run       = 0;
        lvl       = tone_out;
        while (busy === 1'b1 && busy_n < limit) begin
            busy_n++;
            if (tone_out === lvl) begin
                run++;
            end else begin
                if (nruns < 8) runs[nruns] = run;
                nruns++;
                lvl = tone_out;
                run = 1;
            end
            if (done === 1'b1) done_seen++;
            if (busy_n == poke_at) begin
                start    = 1'b1;
                note_sel = 4'd5;
                octave   = 2'd0;
                duration = 16'd7;
            end else begin
                start = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; note_sel = 4'd0; octave = 2'd0; duration = 16'd0;
        start2 = 1'b0; note_sel2 = 4'd0; octave2 = 2'd0; duration2 = 16'd0;
        for (int i = 0; i < 8; i++) runs[i] = 0;

        // Reset
        repeat (5) step();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_tone", 32'(tone_out), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 32'(ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_tone", 32'(tone_out), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);

        // A4, octave 0, 3 ticks
        note_sel = 4'd5; octave = 2'd0; duration = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        check("a4_busy_first", 32'(busy), 32'd1);
        check("a4_tone_first", 32'(tone_out), 32'd1);
        check("a4_ready_first", 32'(ready), 32'd0);
        measure(40000, 0);
        check("a4_busy_cycles", 32'(busy_n), 32'd36000);
        check("a4_high_run", 32'(runs[0]), 32'd13636);
        check("a4_low_run", 32'(runs[1]), 32'd13636);
        check("a4_done_early", 32'(done_seen), 32'd0);
        check("a4_done", 32'(done), 32'd1);
        check("a4_tone_end", 32'(tone_out), 32'd0);
        step();
        check("a4_done_once", 32'(done), 32'd0);

        // C6, octave 3, 1 tick, with an ignored start mid-note
        note_sel = 4'd14; octave = 2'd3; duration = 16'd1; start = 1'b1;
        step();
        start = 1'b0;
        measure(13000, 2000);
        check("c6_busy_cycles", 32'(busy_n), 32'd12000);
        check("c6_high_run", 32'(runs[0]), 32'd716);
        check("c6_low_run", 32'(runs[1]), 32'd716);
        check("c6_run_after_ignore", 32'(runs[5]), 32'd716);
        check("c6_done", 32'(done), 32'd1);
        repeat (3) step();
        check("ignore_no_restart", 32'(busy), 32'd0);
        check("ignore_ready", 32'(ready), 32'd1);

        // Zero duration
        note_sel = 4'd0; octave = 2'd0; duration = 16'd0; start = 1'b1;
        step();
        start = 1'b0;
        check("dur0_done", 32'(done), 32'd1);
        check("dur0_busy", 32'(busy), 32'd0);
        check("dur0_tone", 32'(tone_out), 32'd0);
        check("dur0_ready", 32'(ready), 32'd1);
        step();
        check("dur0_done_clear", 32'(done), 32'd0);
        check("dur0_busy_after", 32'(busy), 32'd0);

        // Clamp: CLOCK_FREQ=8, D6 octave 3 gives H=1, 2 ticks of 8 cycles
        note_sel2 = 4'd15; octave2 = 2'd3; duration2 = 16'd2; start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("clamp_tone_%0d", i), 32'(tone2), (i % 2 == 0) ? 32'd1 : 32'd0);
            step();
        end
        check("clamp_busy_end", 32'(busy2), 32'd0);
        check("clamp_done", 32'(done2), 32'd1);

        // Back-to-back: start held through done, second note aborted by reset
        note_sel = 4'd7; octave = 2'd3; duration = 16'd1; start = 1'b1;
        step();
        note_sel = 4'd0; octave = 2'd0; duration = 16'd5;
        n = 0;
        while (done !== 1'b1 && n < 13000) begin
            n++;
            step();
        end
        check("b2b_first_cycles", 32'(n), 32'd12000);
        check("b2b_done_ready", 32'(ready), 32'd1);
        step();
        start = 1'b0;
        check("b2b_second_busy", 32'(busy), 32'd1);
        check("b2b_second_tone", 32'(tone_out), 32'd1);
        check("b2b_second_done_clear", 32'(done), 32'd0);
        repeat (12000) step();
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        check("mid_tone_before_rst", 32'(tone_out), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tone", 32'(tone_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("mid_rel_ready", 32'(ready), 32'd1);
        check("mid_rel_busy", 32'(busy), 32'd0);
        check("mid_rel_done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
